// File: rtl/nf10_axis_pkg.sv
// rtl/nf10_axis_pkg.sv - shared constants and helpers for the NetFPGA AXIS width converters
package nf10_axis_pkg;

   localparam int RATIO  = 4;
   localparam int LANE_W = $clog2(RATIO);

   // NetFPGA tuser field layout, common to the upsizer and downsizer
   localparam int TUSER_LEN_LO = 0;
   localparam int TUSER_LEN_HI = 15;
   localparam int TUSER_SPT_LO = 16;
   localparam int TUSER_SPT_HI = 23;
   localparam int TUSER_DPT_LO = 24;
   localparam int TUSER_DPT_HI = 31;

   function automatic int strb_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/nf10_axis_upsizer.sv
// rtl/nf10_axis_upsizer.sv - packs narrow AXIS beats into wide beats, keeping packet boundaries and first-beat tuser
module nf10_axis_upsizer
   import nf10_axis_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH = 64,
   parameter int C_M_AXIS_DATA_WIDTH = 256,
   parameter int C_TUSER_WIDTH       = 128
) (
   input  logic                                        axi_aclk,
   input  logic                                        axi_resetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]              s_axis_tdata,
   input  logic [strb_width(C_S_AXIS_DATA_WIDTH)-1:0]  s_axis_tstrb,
   input  logic [C_TUSER_WIDTH-1:0]                    s_axis_tuser,
   input  logic                                        s_axis_tvalid,
   output logic                                        s_axis_tready,
   input  logic                                        s_axis_tlast,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
   output logic [strb_width(C_M_AXIS_DATA_WIDTH)-1:0]  m_axis_tstrb,
   output logic [C_TUSER_WIDTH-1:0]                    m_axis_tuser,
   output logic                                        m_axis_tvalid,
   input  logic                                        m_axis_tready,
   output logic                                        m_axis_tlast
);

   localparam int N_LANES   = C_M_AXIS_DATA_WIDTH / C_S_AXIS_DATA_WIDTH;
   localparam int LANE_BITS = $clog2(N_LANES);
   localparam int S_STRB    = strb_width(C_S_AXIS_DATA_WIDTH);
   localparam int M_STRB    = strb_width(C_M_AXIS_DATA_WIDTH);
   localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(N_LANES - 1);

   logic [C_M_AXIS_DATA_WIDTH-1:0] acc_data, merge_data, ohr_data;
   logic [M_STRB-1:0]              acc_strb, merge_strb, ohr_strb;
   logic [C_TUSER_WIDTH-1:0]       tuser_hold, tuser_pkt, ohr_tuser;
   logic [LANE_BITS-1:0]           lane;
   logic                           first, out_valid, ohr_tlast, ready_en;
   logic                           accept, done;

   // ready_en keeps s_axis_tready low through reset and its first cycle out
   assign s_axis_tready = ready_en && !(out_valid && !m_axis_tready);
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign done          = accept && ((lane == LAST_LANE) || s_axis_tlast);

   always_comb begin
      merge_data = acc_data;
      merge_strb = acc_strb;
      merge_data[lane*C_S_AXIS_DATA_WIDTH +: C_S_AXIS_DATA_WIDTH] = s_axis_tdata;
      merge_strb[lane*S_STRB +: S_STRB] = s_axis_tstrb;
      tuser_pkt = first ? s_axis_tuser : tuser_hold;
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         acc_data   <= '0;
         acc_strb   <= '0;
         lane       <= '0;
         first      <= 1'b1;
         tuser_hold <= '0;
         ohr_data   <= '0;
         ohr_strb   <= '0;
         ohr_tuser  <= '0;
         ohr_tlast  <= 1'b0;
         out_valid  <= 1'b0;
         ready_en   <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (accept) begin
            tuser_hold <= tuser_pkt;
            if (done) begin
               ohr_data  <= merge_data;
               ohr_strb  <= merge_strb;
               ohr_tuser <= tuser_pkt;
               ohr_tlast <= s_axis_tlast;
               out_valid <= 1'b1;
               acc_data  <= '0;
               acc_strb  <= '0;
               lane      <= '0;
               first     <= s_axis_tlast;
            end else begin
               acc_data <= merge_data;
               acc_strb <= merge_strb;
               lane     <= lane + LANE_BITS'(1);
               first    <= 1'b0;
            end
         end
         // A reload in the same cycle as a drain keeps out_valid high
         if (!done && out_valid && m_axis_tready)
            out_valid <= 1'b0;
      end
   end

   assign m_axis_tdata  = ohr_data;
   assign m_axis_tstrb  = ohr_strb;
   assign m_axis_tuser  = ohr_tuser;
   assign m_axis_tlast  = ohr_tlast;
   assign m_axis_tvalid = out_valid;

endmodule
